sample_capture_buffer: RTL and testbench

- Acquisition stage directly upstream of the display comparator.
- Takes the ADC sample stream, decimates it by the timebase select, waits for a rising-edge trigger, and captures one screen width of samples into a ping-pong buffer.
- During display it converts the stored sample for the current pixel column x into a screen row, which the comparator receives on its data input.

---
 rtl/sample_capture_buffer.sv | 168 ++++++++++++++++
 tb/tb_sample_capture_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sample_capture_buffer.sv
// Decimating, edge-triggered capture into a ping-pong buffer, with column-to-row readout for the trace display.
// Readout latency 1 cycle; no backpressure. Optional AUTO_TRIG_EN forces a trigger after AUTO_TIMEOUT waiting ticks.
module sample_capture_buffer #(
    parameter int H_RES        = 640,
    parameter int SAMPLE_W     = 8,
    parameter int DATA_W       = 10,
    parameter int Y_CENTER     = 240,
    parameter int Y_MAX        = 479,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic [1:0]          select,
    input  logic [1:0]          ampselect,
    input  logic                hold,
    input  logic [DATA_W-1:0]   x,
    input  logic [DATA_W-1:0]   y,
    output logic [DATA_W-1:0]   data,
    output logic                armed,
    output logic                triggered,
    output logic                frame_swap
);
    localparam int AW = $clog2(H_RES);
    localparam logic [1:0] S_ARM  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [DATA_W-1:0] H_RES_D   = DATA_W'(H_RES);
    localparam logic [AW-1:0]     LAST_ADDR = AW'(H_RES - 1);
    localparam logic signed [12:0] MID   = 13'(1 << (SAMPLE_W - 1));
    localparam logic signed [13:0] Y_CEN = 14'(Y_CENTER);
    localparam logic signed [13:0] Y_LIM = 14'(Y_MAX);

    logic [1:0]          state, state_nxt;
    logic [1:0]          select_q;
    logic [5:0]          dec_cnt, dec_max;
    logic [AW-1:0]       waddr, wr_addr;
    logic [SAMPLE_W-1:0] prev;
    logic                rd_bank, frame_valid, origin_q;
    logic                sel_chg, tick, frame_start, trig_hit, level_hit, wr_en, swap;

    logic [SAMPLE_W-1:0] mem [0:1][0:H_RES-1];

    always_comb begin
        case (select)
            2'b00:   dec_max = 6'd0;
            2'b01:   dec_max = 6'd3;
            2'b10:   dec_max = 6'd15;
            default: dec_max = 6'd63;
        endcase
    end

    assign sel_chg     = (select != select_q);
    assign tick        = sample_valid && (dec_cnt == dec_max);
    assign frame_start = (x == '0) && (y == '0) && !origin_q;
    assign level_hit   = (prev < trig_level) && (sample_in >= trig_level);

`ifdef AUTO_TRIG_EN
    localparam int AT_W = $clog2(AUTO_TIMEOUT + 1);
    logic [AT_W-1:0] auto_cnt;

    // The tick that would make the count reach AUTO_TIMEOUT fires the trigger itself.
    assign trig_hit = level_hit || (auto_cnt == AT_W'(AUTO_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt <= '0;
        end else if (state != S_WAIT) begin
            auto_cnt <= '0;
        end else if (tick && !sel_chg) begin
            auto_cnt <= auto_cnt + 1'b1;
        end
    end
`else
    assign trig_hit = level_hit;
`endif

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_addr   = waddr;
        swap      = 1'b0;
        if (sel_chg) begin
            state_nxt = S_ARM;
        end else begin
            case (state)
                S_ARM:  if (tick) state_nxt = S_WAIT;
                S_WAIT: if (tick && trig_hit) begin
                    wr_en     = 1'b1;
                    wr_addr   = '0;
                    state_nxt = S_CAP;
                end
                S_CAP:  if (tick) begin
                    wr_en = 1'b1;
                    if (waddr == LAST_ADDR) state_nxt = S_DONE;
                end
                default: if (frame_start && !hold) begin
                    swap      = 1'b1;
                    state_nxt = S_ARM;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_ARM;
            select_q    <= 2'b00;
            dec_cnt     <= '0;
            waddr       <= '0;
            prev        <= '0;
            rd_bank     <= 1'b0;
            frame_valid <= 1'b0;
            origin_q    <= 1'b0;
            armed       <= 1'b0;
            triggered   <= 1'b0;
            frame_swap  <= 1'b0;
        end else begin
            state      <= state_nxt;
            select_q   <= select;
            origin_q   <= (x == '0) && (y == '0);
            armed      <= (state_nxt == S_ARM) || (state_nxt == S_WAIT);
            triggered  <= (state_nxt == S_CAP);
            frame_swap <= swap;
            if (sel_chg || tick) dec_cnt <= '0;
            else if (sample_valid) dec_cnt <= dec_cnt + 1'b1;
            if (wr_en) waddr <= wr_addr + 1'b1;
            if (!sel_chg && tick && ((state == S_ARM) || (state == S_WAIT))) prev <= sample_in;
            if (swap) begin
                rd_bank     <= ~rd_bank;
                frame_valid <= 1'b1;
            end
        end
    end

    // Capture always lands in the bank the display is not reading.
    always_ff @(posedge clk) begin
        if (wr_en) mem[~rd_bank][wr_addr] <= sample_in;
    end

    logic [AW-1:0]         rd_idx;
    logic [SAMPLE_W-1:0]   rd_s;
    logic signed [12:0]    centered, scaled;
    logic signed [13:0]    row;
    logic [DATA_W-1:0]     row_clamped;

    always_comb begin
        rd_idx   = (x < H_RES_D) ? x[AW-1:0] : '0;
        rd_s     = mem[rd_bank][rd_idx];
        centered = $signed(13'(rd_s)) - MID;
        scaled   = centered <<< ampselect;
        row      = Y_CEN - $signed({scaled[12], scaled});
        if (row < 14'sd0)      row_clamped = '0;
        else if (row > Y_LIM)  row_clamped = Y_LIM[DATA_W-1:0];
        else                   row_clamped = row[DATA_W-1:0];
    end

    // All-ones is off-screen, so an invalid column draws nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data <= '1;
        else if (frame_valid && (x < H_RES_D)) data <= row_clamped;
        else data <= '1;
    end

endmodule

// File: tb/tb_sample_capture_buffer.sv
// Directed bench for sample_capture_buffer: transaction-level model checked every cycle plus literal spot checks.
module tb_sample_capture_buffer;
    localparam int H = 640;
    localparam int M_ARM = 0, M_WAIT = 1, M_CAP = 2, M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sample_in, trig_level;
    logic       sample_valid, hold;
    logic [1:0] select, ampselect;
    logic [9:0] x, y, data;
    logic       armed, triggered, frame_swap;

    sample_capture_buffer dut (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .trig_level(trig_level), .select(select), .ampselect(ampselect), .hold(hold),
        .x(x), .y(y), .data(data), .armed(armed), .triggered(triggered), .frame_swap(frame_swap)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int row_of(input int s, input int g);
        int r;
        r = 240 - (s - 128) * (1 << g);
        if (r < 0) r = 0;
        if (r > 479) r = 479;
        return r;
    endfunction

    // Model: captured samples kept as a queue, displayed frame as a plain array.
    int m_mode, m_cnt, m_prev, m_sel, m_wait, m_s;
    bit m_valid, m_origin, m_tick, m_fs, m_hit;
    int cap[$];
    int disp[H];
    int exp_data, exp_armed, exp_trig, exp_swap;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_ARM; m_cnt = 0; m_prev = 0; m_sel = 0; m_wait = 0;
            m_valid = 0; m_origin = 0; cap.delete();
            exp_data = 1023; exp_armed = 0; exp_trig = 0; exp_swap = 0;
        end else begin
            m_fs     = (x == 0) && (y == 0) && !m_origin;
            m_origin = (x == 0) && (y == 0);
            exp_data = (m_valid && x < H) ? row_of(disp[x], ampselect) : 1023;
            exp_swap = 0;
            m_tick   = 0;
            m_s      = sample_in;
            if (select != m_sel) begin
                m_sel = select; m_cnt = 0; m_mode = M_ARM; cap.delete();
            end else begin
                if (sample_valid) begin
                    m_cnt++;
                    if (m_cnt == (1 << (2 * select))) begin m_tick = 1; m_cnt = 0; end
                end
                case (m_mode)
                    M_ARM: if (m_tick) begin m_prev = m_s; m_mode = M_WAIT; m_wait = 0; end
                    M_WAIT: if (m_tick) begin
                        m_hit = (m_prev < trig_level) && (m_s >= trig_level);
`ifdef AUTO_TRIG_EN
                        m_wait++;
                        if (m_wait == 4096) m_hit = 1;
`endif
                        if (m_hit) begin cap.delete(); cap.push_back(m_s); m_mode = M_CAP; end
                        m_prev = m_s;
                    end
                    M_CAP: if (m_tick) begin
                        cap.push_back(m_s);
                        if (cap.size() == H) m_mode = M_DONE;
                    end
                    default: if (m_fs && !hold) begin
                        for (int i = 0; i < H; i++) disp[i] = cap[i];
                        m_valid = 1; exp_swap = 1; m_mode = M_ARM; cap.delete();
                    end
                endcase
            end
            exp_armed = (m_mode == M_ARM || m_mode == M_WAIT) ? 1 : 0;
            exp_trig  = (m_mode == M_CAP) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_data", data, exp_data);
            check("model_armed", armed, exp_armed);
            check("model_triggered", triggered, exp_trig);
            check("model_frame_swap", frame_swap, exp_swap);
        end
    end

    int ramp = 0;

    // One sample strobe per cycle until the capture completes (both status flags low).
    task automatic run_capture(input string name, input int budget, output int n_hi, output int trig_s);
        int last;
        bit seen;
        n_hi = 0; trig_s = -1; seen = 0;
        for (int i = 0; i < budget; i++) begin
            sample_in = 8'(ramp); sample_valid = 1'b1; last = ramp % 256; ramp++;
            @(negedge clk);
            if (triggered && !seen) begin seen = 1; trig_s = last; end
            if (triggered) n_hi++;
            if (seen && !triggered && !armed) break;
        end
        sample_valid = 1'b0;
        check({name, "_reached_done"}, int'(seen && !triggered && !armed), 1);
    endtask

    task automatic frame_start(input string name, input int exp_sw);
        x = 0; y = 0;
        @(negedge clk);
        check(name, frame_swap, exp_sw);
        x = 1; y = 0;
        @(negedge clk);
        check({name, "_pulse_end"}, frame_swap, 0);
        x = 28; y = 1;
    endtask

    task automatic read_px(input string name, input int px, input int g, input int exp);
        x = 10'(px); ampselect = 2'(g);
        @(negedge clk);
        check(name, data, exp);
    endtask

    int n_hi, trig_s, n;

    initial begin
        sample_in = 0; sample_valid = 0; trig_level = 8'd100; select = 0; ampselect = 0;
        hold = 0; x = 700; y = 1; rst_n = 0;
        repeat (3) @(negedge clk);
        check("rst_data", data, 1023);
        check("rst_armed", armed, 0);
        check("rst_triggered", triggered, 0);
        check("rst_frame_swap", frame_swap, 0);
        rst_n = 1;
        @(negedge clk);
        check("armed_after_rst", armed, 1);

        // Full-rate ramp capture: stored sample at address a is (100+a)%256.
        x = 28;
        run_capture("ramp", 2000, n_hi, trig_s);
        check("trig_sample", trig_s, 100);
        check("cap_ticks_high", n_hi, 639);
        check("pre_swap_blank", data, 1023);
        frame_start("first_swap", 1);
        read_px("mid_sample", 28, 0, 240);
        read_px("full_scale", 155, 0, 113);
        read_px("clamp_low", 155, 3, 0);
        read_px("clamp_high", 156, 2, 479);
        read_px("offscreen_640", 640, 0, 1023);
        read_px("offscreen_799", 799, 0, 1023);

        // Decimate by 16.
        select = 2'b10;
        @(negedge clk);
        check("sel_rearm", armed, 1);
        run_capture("dec16", 20000, n_hi, trig_s);
        check("dec16_strobes", n_hi, 639 * 16);
        frame_start("dec16_swap", 1);
        for (int i = 0; i < H; i++) begin
            x = 10'(i); ampselect = 2'(i % 4);
            @(negedge clk);
        end
        ampselect = 0; x = 28;

        // Abort a capture midway by changing timebase.
        n = 0;
        for (int i = 0; i < 5000; i++) begin
            sample_in = 8'(ramp); sample_valid = 1'b1; ramp++;
            @(negedge clk);
            if (triggered) n++;
            if (n == 100) break;
        end
        check("abort_in_capture", triggered, 1);
        select = 2'b01;
        @(negedge clk);
        check("abort_armed", armed, 1);
        check("abort_triggered", triggered, 0);
        sample_valid = 1'b0;
        frame_start("abort_no_swap", 0);

        // Hold blocks the swap but not the acquisition.
        hold = 1;
        run_capture("hold", 6000, n_hi, trig_s);
        check("hold_cap_ticks", n_hi, 639 * 4);
        frame_start("hold_fs1", 0);
        frame_start("hold_fs2", 0);
        frame_start("hold_fs3", 0);
        hold = 0;
        frame_start("hold_release", 1);

        // Flat input below the threshold.
        select = 2'b00; sample_valid = 0;
        @(negedge clk);
        n = 0;
        for (int i = 0; i < 5000; i++) begin
            sample_in = 8'd50; sample_valid = 1'b1;
            @(negedge clk);
            n++;
            if (triggered) break;
        end
        sample_valid = 1'b0;
`ifdef AUTO_TRIG_EN
        check("auto_trig_strobes", n, 4097);
        check("auto_triggered", triggered, 1);
`else
        check("flat_armed", armed, 1);
        check("flat_not_triggered", triggered, 0);
`endif
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
